// File: rtl/systolic_pkg.sv
// Shared types for the weight-stationary systolic array, its feeder and its drain.
package systolic_pkg;
  localparam int PSUM_W    = 32;
  localparam int ACT_W     = 8;
  localparam int MAX_LANES = 64;

  typedef logic signed [PSUM_W-1:0] psum_t;

  // Lane j of a packed lane vector (lane 0 in the LSBs); callers zero-pad to MAX_LANES.
  function automatic psum_t lane(input logic [MAX_LANES*PSUM_W-1:0] vec, input int unsigned j);
    return psum_t'(vec[j*PSUM_W +: PSUM_W]);
  endfunction
endpackage

// File: rtl/systolic_drain_if.sv
// Aligned-row stream from the drain to the downstream consumer.
interface systolic_drain_if #(
  parameter int COLS   = 4,
  parameter int PSUM_W = 32
);
  logic [COLS*PSUM_W-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/systolic_drain_fifo.sv
// Row FIFO for the drain: power-of-2 depth, accepts a write while full if a pop
// happens in the same cycle (the freed head slot is the one being written).
module drain_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/systolic_drain.sv
// South-edge collector: deskews the per-column psum stream into whole rows,
// optionally clamps negatives, buffers rows and never stalls the array;
// rows arriving with no room are dropped and counted.
module systolic_drain #(
  parameter int COLS     = 4,
  parameter int PSUM_W   = systolic_pkg::PSUM_W,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int RELU     = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [COLS*PSUM_W-1:0]     psum_in,
  input  logic                       psum_valid,
  systolic_drain_if.master           out_if,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  input  logic                       clr_ovf
);
  import systolic_pkg::*;

  localparam int STAGES = COLS - 1;
  localparam int CW     = $clog2(DEPTH+1);
  localparam int W      = COLS * PSUM_W;

  logic [COLS-1:0][PSUM_W-1:0] aligned, row;
  logic [STAGES:0]             vld_pipe;
  logic                        wr_en, push, pop, drop, full, empty;
  logic [W-1:0]                dout;
  logic [CW-1:0]               cnt_nxt;

  // Row-valid chain: tap STAGES lines up with the last lane of the row.
  if (STAGES > 0) begin : g_vld
    logic [STAGES:1] vld_q;
    assign vld_pipe = {vld_q, psum_valid};
    // Shift the controller pulse along with the skew.
    always_ff @(posedge clk) begin
      if (!reset_n) vld_q <= '0;
      else          vld_q <= vld_pipe[STAGES-1:0];
    end
  end else begin : g_vld0
    assign vld_pipe = psum_valid;
  end

  assign wr_en = vld_pipe[STAGES];

  // Lane j arrives j cycles after lane 0, so it is delayed COLS-1-j cycles.
  for (genvar j = 0; j < COLS; j++) begin : g_lane
    localparam int D = COLS - 1 - j;
    logic [PSUM_W-1:0] din;
    assign din = psum_in[j*PSUM_W +: PSUM_W];
    if (D == 0) begin : g_thru
      assign aligned[j] = din;
    end else begin : g_dly
      logic [D-1:0][PSUM_W-1:0] sr;
      // Deskew shift register, sr[0] newest.
      always_ff @(posedge clk) begin
        if (!reset_n) sr <= '0;
        else begin
          sr[0] <= din;
          for (int s = 1; s < D; s++) sr[s] <= sr[s-1];
        end
      end
      assign aligned[j] = sr[D-1];
    end
    assign row[j] = (RELU != 0 && aligned[j][PSUM_W-1]) ? '0 : aligned[j];
  end

  assign pop  = out_if.out_valid && out_if.out_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  drain_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (row),
    .dout    (dout),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign out_if.out_valid = !empty;
  assign out_if.out_data  = empty ? '0 : dout;
  assign cnt_nxt          = fifo_count + CW'(push) - CW'(pop);

  // almost_full follows the next count so it lines up with fifo_count.
  always_ff @(posedge clk) begin
    if (!reset_n) almost_full <= 1'b0;
    else          almost_full <= (cnt_nxt >= CW'(AF_LEVEL));
  end

  // Drop bookkeeping; a drop in the same cycle as a clear restarts the count at 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                     drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clr_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end
endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench: two drains (RELU off / on) share the same south-edge stimulus.
module tb_systolic_drain;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0, psum_valid = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [127:0] psum_in = '0;
  logic [3:0]   cnt0, cnt1;
  logic         af0, af1, ovf0, ovf1;
  logic [15:0]  dc0, dc1;

  systolic_drain_if #(.COLS(4), .PSUM_W(32)) bus0 ();
  systolic_drain_if #(.COLS(4), .PSUM_W(32)) bus1 ();
  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;

  systolic_drain #(.COLS(4), .PSUM_W(32), .DEPTH(8), .AF_LEVEL(6), .RELU(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .psum_in(psum_in), .psum_valid(psum_valid),
    .out_if(bus0), .fifo_count(cnt0), .almost_full(af0), .overflow(ovf0),
    .drop_count(dc0), .clr_ovf(clr_ovf));

  systolic_drain #(.COLS(4), .PSUM_W(32), .DEPTH(8), .AF_LEVEL(6), .RELU(1)) u_relu (
    .clk(clk), .reset_n(reset_n), .psum_in(psum_in), .psum_valid(psum_valid),
    .out_if(bus1), .fifo_count(cnt1), .almost_full(af1), .overflow(ovf1),
    .drop_count(dc1), .clr_ovf(clr_ovf));

  always #5 clk = ~clk;

  int           checks = 0, errors = 0, cyc_n = 0;
  logic [31:0]  fut [4][4];
  logic         has [4][4];
  logic [127:0] got0 [$];
  logic [127:0] got1 [$];
  int           pop_cyc [$];
  int           exp_cnt [10] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7};
  int           exp_af  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkr(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mkrow(input int k);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'(16*k + j);
    return r;
  endfunction

  // One clock cycle: a row issued now has lane j on the bus j cycles later;
  // lanes with nothing scheduled carry random garbage.
  task automatic cyc(input logic v, input logic [127:0] r, input logic rdy);
    if (v) for (int j = 0; j < 4; j++) begin
      fut[j][j] = r[j*32 +: 32];
      has[j][j] = 1'b1;
    end
    for (int j = 0; j < 4; j++) psum_in[j*32 +: 32] = has[j][0] ? fut[j][0] : $urandom;
    psum_valid = v;
    out_ready  = rdy;
    if (bus0.out_valid && rdy) begin
      got0.push_back(bus0.out_data);
      pop_cyc.push_back(cyc_n);
    end
    if (bus1.out_valid && rdy) got1.push_back(bus1.out_data);
    @(posedge clk);
    #1;
    cyc_n++;
    for (int j = 0; j < 4; j++) begin
      for (int d = 0; d < 3; d++) begin
        fut[j][d] = fut[j][d+1];
        has[j][d] = has[j][d+1];
      end
      has[j][3] = 1'b0;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy);
  endtask

  initial begin
    logic [127:0] r, rv, rr;
    for (int j = 0; j < 4; j++) for (int d = 0; d < 4; d++) begin
      has[j][d] = 1'b0;
      fut[j][d] = '0;
    end

    // Reset state
    reset_n = 1'b0;
    idle(2, 1'b0);
    chk("rst out_valid", 32'(bus0.out_valid), 0);
    chk("rst fifo_count", 32'(cnt0), 0);
    chk("rst almost_full", 32'(af0), 0);
    chk("rst overflow", 32'(ovf0), 0);
    chk("rst drop_count", 32'(dc0), 0);
    chkr("rst out_data", bus0.out_data, '0);
    reset_n = 1'b1;
    idle(2, 1'b0);

    // Single row, latency COLS, hold while not ready, then pop
    got0.delete();
    r = {32'd103, 32'd102, 32'd101, 32'd100};
    cyc(1'b1, r, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t1 early out_valid", 32'(bus0.out_valid), 0);
      cyc(1'b0, '0, 1'b0);
    end
    chk("t1 out_valid", 32'(bus0.out_valid), 1);
    chk("t1 count", 32'(cnt0), 1);
    chkr("t1 out_data", bus0.out_data, r);
    cyc(1'b0, '0, 1'b0);
    chkr("t1 hold out_data", bus0.out_data, r);
    cyc(1'b0, '0, 1'b1);
    chk("t1 count after pop", 32'(cnt0), 0);
    chk("t1 out_valid after pop", 32'(bus0.out_valid), 0);
    chk("t1 pops", got0.size(), 1);
    chkr("t1 popped row", got0[0], r);

    // Back-to-back rows with a ready consumer
    got0.delete();
    pop_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, mkrow(k), 1'b1);
      chk("t2 count<=1", 32'(cnt0 <= 4'd1), 1);
      chk("t2 overflow", 32'(ovf0), 0);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("t2 count<=1", 32'(cnt0 <= 4'd1), 1);
    end
    chk("t2 rows", got0.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chkr("t2 row", got0[k], mkrow(k));
      chk("t2 no gap", pop_cyc[k], pop_cyc[0] + k);
    end

    // Overflow with a stalled consumer
    got0.delete();
    for (int n = 0; n < 10; n++) begin
      cyc(1'b1, mkrow(10 + n), 1'b0);
      chk("t3 count", 32'(cnt0), exp_cnt[n]);
      chk("t3 almost_full", 32'(af0), exp_af[n]);
    end
    cyc(1'b0, '0, 1'b0);
    chk("t3 count full", 32'(cnt0), 8);
    chk("t3 overflow before drop", 32'(ovf0), 0);
    idle(4, 1'b0);
    chk("t3 count", 32'(cnt0), 8);
    chk("t3 almost_full", 32'(af0), 1);
    chk("t3 overflow", 32'(ovf0), 1);
    chk("t3 drop_count", 32'(dc0), 2);
    // drop in the same cycle as clr_ovf: the drop wins
    cyc(1'b1, mkrow(99), 1'b0);
    idle(2, 1'b0);
    clr_ovf = 1'b1;
    cyc(1'b0, '0, 1'b0);
    clr_ovf = 1'b0;
    chk("t3 clr+drop overflow", 32'(ovf0), 1);
    chk("t3 clr+drop drop_count", 32'(dc0), 1);
    idle(10, 1'b1);
    chk("t3 drained rows", got0.size(), 8);
    for (int k = 0; k < 8; k++) chkr("t3 drained row", got0[k], mkrow(10 + k));
    chk("t3 count empty", 32'(cnt0), 0);
    chk("t3 almost_full clear", 32'(af0), 0);
    clr_ovf = 1'b1;
    cyc(1'b0, '0, 1'b0);
    clr_ovf = 1'b0;
    chk("t3 clr overflow", 32'(ovf0), 0);
    chk("t3 clr drop_count", 32'(dc0), 0);

    // Full FIFO with a pop exactly in the write cycle
    got0.delete();
    for (int k = 0; k < 8; k++) cyc(1'b1, mkrow(20 + k), 1'b0);
    idle(3, 1'b0);
    chk("t4 count full", 32'(cnt0), 8);
    cyc(1'b1, mkrow(28), 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("t4 count stays", 32'(cnt0), 8);
    chk("t4 drop_count", 32'(dc0), 0);
    chk("t4 overflow", 32'(ovf0), 0);
    idle(10, 1'b1);
    chk("t4 rows", got0.size(), 9);
    for (int k = 0; k < 9; k++) chkr("t4 row", got0[k], mkrow(20 + k));

    // RELU clamp vs pass-through
    got0.delete();
    got1.delete();
    rv = {32'h8000_0000, 32'd7, 32'd0, 32'hFFFF_FFFB};
    rr = {32'd0, 32'd7, 32'd0, 32'd0};
    cyc(1'b1, rv, 1'b1);
    idle(6, 1'b1);
    chk("t5 rows relu0", got0.size(), 1);
    chkr("t5 relu0 row", got0[0], rv);
    chk("t5 rows relu1", got1.size(), 1);
    chkr("t5 relu1 row", got1[0], rr);

    // Reset mid-flight: in-flight rows lost, post-reset row normal
    got0.delete();
    cyc(1'b1, mkrow(40), 1'b0);
    cyc(1'b1, mkrow(41), 1'b0);
    reset_n = 1'b0;
    cyc(1'b1, mkrow(42), 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t6 out_valid after reset", 32'(bus0.out_valid), 0);
      chk("t6 count after reset", 32'(cnt0), 0);
      cyc(1'b0, '0, 1'b0);
    end
    cyc(1'b1, mkrow(50), 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t6 early out_valid", 32'(bus0.out_valid), 0);
      cyc(1'b0, '0, 1'b0);
    end
    chk("t6 out_valid", 32'(bus0.out_valid), 1);
    chk("t6 count", 32'(cnt0), 1);
    chkr("t6 out_data", bus0.out_data, mkrow(50));
    idle(3, 1'b1);
    chk("t6 rows", got0.size(), 1);
    chk("t6 count drained", 32'(cnt0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
